// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: drives the PC enable, the PC mux select and the IF/ID write/flush.
// It reacts to the imem handshake, load-use stalls and EX branch redirects, and locks into a sticky fault on memory timeout.
module fetch_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall_req,
    input  logic       branch_taken,
    input  logic       imem_ready,
    output logic       imem_req,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       IF_ID_WriteEnable,
    output logic       IF_ID_Flush,
    output logic       fetch_fault,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        STALL = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, cnt_nxt;

    // Handshake: imem_req is held high while a word is wanted; a cycle with both
    // imem_req and imem_ready high delivers the word for the PC presented that cycle.
    // Outputs are Mealy so that the PC and IF/ID registers act on the same edge.
    always_comb begin
        state_nxt         = state;
        cnt_nxt           = wait_cnt;
        imem_req          = 1'b0;
        PCWrite           = 1'b0;
        PCSrc             = 1'b0;
        IF_ID_WriteEnable = 1'b0;
        IF_ID_Flush       = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH, WAIT, STALL: begin
                if (branch_taken) begin
                    imem_req    = 1'b1;
                    PCWrite     = 1'b1;
                    PCSrc       = 1'b1;
                    IF_ID_Flush = 1'b1;
                    state_nxt   = FETCH;
                    cnt_nxt     = '0;
                end else if (state == STALL) begin
                    if (!stall_req) state_nxt = FETCH;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        cnt_nxt = '0;
                        if (stall_req) begin
                            state_nxt = STALL;
                        end else begin
                            PCWrite           = 1'b1;
                            IF_ID_WriteEnable = 1'b1;
                            state_nxt         = FETCH;
                        end
                    end else if (state == FETCH) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(1);
                    end else if (wait_cnt == CNT_MAX) begin
                        state_nxt = FAULT;
                    end else begin
                        cnt_nxt = wait_cnt + 1'b1;
                    end
                end
            end
            FAULT: state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= cnt_nxt;
            fetch_fault <= (state_nxt == FAULT);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: each task drives per-cycle vectors and checks the packed outputs inline.
// Packed observation: {imem_req, PCWrite, PCSrc, IF_ID_WriteEnable, IF_ID_Flush, fetch_fault, state_dbg}.
module tb_fetch_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stall_req = 1'b0;
    logic       branch_taken = 1'b0;
    logic       imem_ready = 1'b0;
    logic       imem_req, PCWrite, PCSrc, IF_ID_WriteEnable, IF_ID_Flush, fetch_fault;
    logic [2:0] state_dbg;
    logic [8:0] obs;

    int vectors = 0;
    int errors  = 0;

    localparam logic [8:0] O_IDLE     = 9'b0_0_0_0_0_0_000;
    localparam logic [8:0] O_FETCH_OK = 9'b1_1_0_1_0_0_001;
    localparam logic [8:0] O_FETCH_NO = 9'b1_0_0_0_0_0_001;
    localparam logic [8:0] O_WAIT_NO  = 9'b1_0_0_0_0_0_010;
    localparam logic [8:0] O_WAIT_OK  = 9'b1_1_0_1_0_0_010;
    localparam logic [8:0] O_STALL    = 9'b0_0_0_0_0_0_011;
    localparam logic [8:0] O_RED_F    = 9'b1_1_1_0_1_0_001;
    localparam logic [8:0] O_RED_W    = 9'b1_1_1_0_1_0_010;
    localparam logic [8:0] O_RED_S    = 9'b1_1_1_0_1_0_011;
    localparam logic [8:0] O_FAULT    = 9'b0_0_0_0_0_1_100;

    fetch_controller #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .stall_req(stall_req),
        .branch_taken(branch_taken),
        .imem_ready(imem_ready),
        .imem_req(imem_req),
        .PCWrite(PCWrite),
        .PCSrc(PCSrc),
        .IF_ID_WriteEnable(IF_ID_WriteEnable),
        .IF_ID_Flush(IF_ID_Flush),
        .fetch_fault(fetch_fault),
        .state_dbg(state_dbg)
    );

    assign obs = {imem_req, PCWrite, PCSrc, IF_ID_WriteEnable, IF_ID_Flush, fetch_fault, state_dbg};

    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_hold: got %b want %b", obs, O_IDLE);
        end
        @(negedge clk);
        imem_ready = 1'b1;
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_cycle0: got %b want %b", obs, O_IDLE);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (obs !== O_FETCH_OK) begin
                errors++;
                $display("FAIL reset_stream[%0d]: got %b want %b", i, obs, O_FETCH_OK);
            end
        end
    endtask

    task automatic test_wait();
        logic [2:0] st [5] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b010};
        logic [8:0] ex [5] = '{O_FETCH_NO, O_WAIT_NO, O_WAIT_NO, O_WAIT_OK, O_FETCH_OK};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            {branch_taken, imem_ready, stall_req} = st[i];
            #1;
            vectors++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL wait[%0d]: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [2:0] st [4] = '{3'b011, 3'b011, 3'b010, 3'b010};
        logic [8:0] ex [4] = '{O_FETCH_NO, O_STALL, O_STALL, O_FETCH_OK};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {branch_taken, imem_ready, stall_req} = st[i];
            #1;
            vectors++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL stall[%0d]: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0] st [6] = '{3'b101, 3'b000, 3'b100, 3'b011, 3'b101, 3'b010};
        logic [8:0] ex [6] = '{O_RED_F, O_FETCH_NO, O_RED_W, O_FETCH_NO, O_RED_S, O_FETCH_OK};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            {branch_taken, imem_ready, stall_req} = st[i];
            #1;
            vectors++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL branch[%0d]: got %b want %b", i, obs, ex[i]);
            end
        end
    endtask

    // Ready arrives on the last cycle before the timeout would fire.
    task automatic test_timeout_edge();
        logic [8:0] ex;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            branch_taken = 1'b0;
            stall_req    = 1'b0;
            imem_ready   = (i >= 15);
            if (i == 0)       ex = O_FETCH_NO;
            else if (i < 15)  ex = O_WAIT_NO;
            else if (i == 15) ex = O_WAIT_OK;
            else              ex = O_FETCH_OK;
            #1;
            vectors++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL timeout_edge[%0d]: got %b want %b", i, obs, ex);
            end
        end
    endtask

    task automatic test_timeout();
        logic [8:0] ex;
        for (int i = 0; i <= 19; i++) begin
            @(negedge clk);
            branch_taken = (i >= 17);
            imem_ready   = (i >= 17);
            stall_req    = 1'b0;
            if (i == 0)      ex = O_FETCH_NO;
            else if (i < 16) ex = O_WAIT_NO;
            else             ex = O_FAULT;
            #1;
            vectors++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL timeout[%0d]: got %b want %b", i, obs, ex);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_from_fault: got %b want %b", obs, O_IDLE);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (obs !== O_FETCH_NO) begin
            errors++;
            $display("FAIL refetch_after_reset: got %b want %b", obs, O_FETCH_NO);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (obs !== O_WAIT_NO) begin
            errors++;
            $display("FAIL wait_before_reset: got %b want %b", obs, O_WAIT_NO);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_mid_wait: got %b want %b", obs, O_IDLE);
        end
        @(negedge clk);
        imem_ready = 1'b1;
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== O_IDLE) begin
            errors++;
            $display("FAIL idle_after_release: got %b want %b", obs, O_IDLE);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (obs !== O_FETCH_OK) begin
            errors++;
            $display("FAIL fetch_after_release: got %b want %b", obs, O_FETCH_OK);
        end
    endtask

    initial begin
        test_reset();
        test_wait();
        test_stall();
        test_branch();
        test_timeout_edge();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
